mac_array_ctrl: RTL and testbench

Sequencer that drives the instruction/mode inputs of the 2-D MAC array (stacked mac_row instances) and the read strobe of the L0 input buffer that feeds the array's west edge. Per job it runs kernel load, flush, execute and drain phases, then pulses done. It sits between the top-level core controller (start/num_vec/mode) and the L0 + array datapath. Weight-stationary (mode=0) and output-stationary (mode=1) jobs are both supported.

---
 rtl/mac_ctrl_pkg.sv | 21 ++
 rtl/mac_array_ctrl_l0_issue_ctr.sv | 45 ++++
 rtl/mac_array_ctrl.sv | 129 ++++++++++++
 tb/tb_mac_array_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared encodings for the MAC array sequencer: FSM states, array
// instruction opcodes and job modes.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KLOAD  = 3'd1,
    ST_KFLUSH = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] INST_NOP   = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_array_ctrl_l0_issue_ctr.sv
// Gated L0 read issue with a target count, plus the instruction register
// that lines inst_w up with the L0 read data one cycle after each read.
module l0_issue_ctr
  import mac_ctrl_pkg::*;
#(
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              l0_empty,
  input  logic [cnt_bw-1:0] target,
  input  logic [1:0]        opcode,
  output logic              rd,
  output logic              last,
  output logic [1:0]        inst_w
);

  localparam logic [cnt_bw-1:0] one = {{(cnt_bw-1){1'b0}}, 1'b1};

  logic [cnt_bw-1:0] count;

  // Read only when L0 has data and the phase target is not yet reached.
  // NOTE: every always_comb output gets a value on every path; a missing
  // branch would infer a latch.
  always_comb begin
    rd   = en && !l0_empty && (count < target);
    last = rd && (count == target - one);
  end

  // Issue counter restarts whenever issuing is disabled; inst_w follows rd by one cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      inst_w <= INST_NOP;
    end else begin
      if (!en)     count <= '0;
      else if (rd) count <= count + one;
      inst_w <= rd ? opcode : INST_NOP;
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the MAC array: kernel load, flush, execute and drain
// phases, driving the L0 read strobe and the array instruction/mode inputs.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int cnt_bw    = 8,
  parameter int flush_cyc = row + col
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic [cnt_bw-1:0] num_vec,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [1:0]        inst_w,
  output logic              mode,
  input  logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase
);

  localparam int fw = $clog2(flush_cyc + 1);
  localparam logic [fw-1:0]     flush_last = fw'(flush_cyc - 1);
  localparam logic [cnt_bw-1:0] col_cnt    = cnt_bw'(col);
  localparam logic [cnt_bw-1:0] one        = {{(cnt_bw-1){1'b0}}, 1'b1};

  state_t            state;
  logic [cnt_bw-1:0] num_vec_q;
  logic [cnt_bw-1:0] out_count;
  logic [fw-1:0]     flush_cnt;

  logic              issue_en;
  logic              issue_last;
  logic [cnt_bw-1:0] issue_target;
  logic [1:0]        issue_op;
  logic              out_hit;

  // One issue counter serves both load and execute phases.
  always_comb begin
    issue_en     = (state == ST_KLOAD) || (state == ST_EXEC);
    issue_target = (state == ST_KLOAD) ? col_cnt : num_vec_q;
    issue_op     = (state == ST_KLOAD) ? INST_KLOAD : INST_EXEC;
    // Drain completes on the cycle the last output arrives, not one later.
    out_hit      = (out_count == num_vec_q) ||
                   (out_valid && (out_count == num_vec_q - one));
  end

  l0_issue_ctr #(.cnt_bw(cnt_bw)) u_issue (
    .clk      (clk),
    .reset    (reset),
    .en       (issue_en),
    .l0_empty (l0_empty),
    .target   (issue_target),
    .opcode   (issue_op),
    .rd       (l0_rd),
    .last     (issue_last),
    .inst_w   (inst_w)
  );

  assign phase = state;

  // Job FSM with registered mode/busy/done and saturating output counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode      <= MODE_WS;
      num_vec_q <= '0;
      out_count <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if ((state == ST_EXEC || state == ST_DRAIN) && out_valid &&
          (out_count != num_vec_q))
        out_count <= out_count + one;

      case (state)
        ST_IDLE: begin
          if (start) begin
            mode      <= mode_in;
            num_vec_q <= num_vec;
            out_count <= '0;
            flush_cnt <= '0;
            busy      <= 1'b1;
            if (num_vec == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (mode_in == MODE_OS) begin
              state <= ST_EXEC;
            end else begin
              state <= ST_KLOAD;
            end
          end
        end
        ST_KLOAD: begin
          if (issue_last) begin
            state     <= ST_KFLUSH;
            flush_cnt <= '0;
          end
        end
        ST_KFLUSH: begin
          if (flush_cnt == flush_last) state <= ST_EXEC;
          else                         flush_cnt <= flush_cnt + 1'b1;
        end
        ST_EXEC: begin
          if (issue_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_hit) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: stimulus pushes expected instruction
// streams and job outcomes; a monitor with a D-cycle array model pops them.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int COL = 8;
  localparam int D   = 10;

  logic       clk = 1'b0;
  logic       reset, start, mode_in;
  logic [7:0] num_vec;
  logic       l0_empty, l0_rd;
  logic [1:0] inst_w;
  logic       mode, out_valid, busy, done;
  logic [2:0] phase;

  always #5 clk = ~clk;

  mac_array_ctrl #(.row(8), .col(COL), .cnt_bw(8), .flush_cyc(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode_in   (mode_in),
    .num_vec   (num_vec),
    .l0_empty  (l0_empty),
    .l0_rd     (l0_rd),
    .inst_w    (inst_w),
    .mode      (mode),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .phase     (phase)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int nvec;
    int reads;
    int gap;
    int first_phase;
    int md;
  } job_t;

  job_t       job_q[$];
  logic [1:0] inst_q[$];
  int         jobs_done = 0;
  bit         toggle_empty = 0;

  // monitor state
  int         cyc = 0;
  int         reads, exec_reads, ov_count, last_ov, last_k, gap, first_phase;
  bit         got_first_exec;
  logic       prev_rd;
  logic [2:0] prev_phase;
  logic [D-1:0] pipe;
  logic [1:0] exp_iw;
  job_t       jd;

  // L0 occupancy driver
  initial begin
    l0_empty = 1'b0;
    forever begin
      @(negedge clk);
      l0_empty = toggle_empty ? ~l0_empty : 1'b0;
    end
  end

  // Monitor + array model: samples two time units before each rising edge.
  initial begin
    out_valid  = 1'b0;
    pipe       = '0;
    prev_rd    = 1'b0;
    prev_phase = ST_IDLE;
    reads = 0; exec_reads = 0; ov_count = 0; last_ov = -100; last_k = -1; gap = -1;
    first_phase = 0; got_first_exec = 0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        pipe       = '0;
        out_valid  = 1'b0;
        prev_rd    = 1'b0;
        prev_phase = ST_IDLE;
      end else begin
        if (prev_phase == ST_IDLE && phase != ST_IDLE) begin
          reads = 0; exec_reads = 0; ov_count = 0; last_ov = -100;
          last_k = -1; gap = -1; got_first_exec = 0; first_phase = phase;
        end
        if (l0_rd) begin
          check("rd_while_empty", l0_empty, 0);
          reads++;
          if (phase == ST_EXEC) exec_reads++;
        end
        exp_iw = !prev_rd ? INST_NOP : (prev_phase == ST_KLOAD) ? INST_KLOAD : INST_EXEC;
        if (busy || prev_rd) check("inst_align", inst_w, exp_iw);
        if (inst_w != INST_NOP) begin
          if (inst_q.size() == 0) check("inst_unexpected", inst_w, INST_NOP);
          else                    check("inst_seq", inst_w, inst_q.pop_front());
        end
        if (inst_w == INST_KLOAD) last_k = cyc;
        if (inst_w == INST_EXEC && !got_first_exec) begin
          got_first_exec = 1;
          if (last_k >= 0) gap = cyc - last_k;
        end
        if (busy && job_q.size() != 0) check("mode_hold", mode, job_q[0].md);
        if (done) begin
          if (job_q.size() == 0) check("done_unexpected", done, 0);
          else begin
            jd = job_q.pop_front();
            check("done_phase", phase, ST_DONE);
            check("done_busy", busy, 1);
            check("done_mode", mode, jd.md);
            check("done_reads", reads, jd.reads);
            check("first_phase", first_phase, jd.first_phase);
            if (jd.nvec > 0) begin
              check("exec_reads", exec_reads, jd.nvec);
              check("ov_count", ov_count, jd.nvec);
              check("done_after_ov", cyc - last_ov, 1);
            end
            if (jd.gap >= 0) check("flush_gap", gap, jd.gap);
            jobs_done++;
          end
        end
        // Array pipeline: each execute instruction yields out_valid D cycles later.
        out_valid = pipe[D-1];
        pipe = {pipe[D-2:0], (inst_w == INST_EXEC)};
        if (out_valid) begin
          ov_count++;
          last_ov = cyc;
        end
        prev_rd    = l0_rd;
        prev_phase = phase;
      end
      cyc++;
    end
  end

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic push_job(input int md, input int nvec, input int gp);
    job_t j;
    j.nvec        = nvec;
    j.md          = md;
    j.gap         = gp;
    j.reads       = (nvec == 0) ? 0 : (md != 0) ? nvec : COL + nvec;
    j.first_phase = (nvec == 0) ? int'(ST_DONE) : (md != 0) ? int'(ST_EXEC) : int'(ST_KLOAD);
    job_q.push_back(j);
    if (nvec > 0 && md == 0) repeat (COL) inst_q.push_back(INST_KLOAD);
    repeat (nvec) inst_q.push_back(INST_EXEC);
  endtask

  // extra: 1 = hold start a second cycle, 2 = re-pulse start mid-job
  task automatic run_job(input int md, input int nvec, input int gp, input bit tog, input int extra);
    int target;
    push_job(md, nvec, gp);
    target = jobs_done + 1;
    @(negedge clk);
    toggle_empty = tog;
    start   = 1'b1;
    mode_in = md[0];
    num_vec = nvec[7:0];
    @(negedge clk);
    start   = (extra == 1);
    mode_in = ~md[0];
    @(negedge clk);
    start = 1'b0;
    if (extra == 2) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 2000 && jobs_done < target; k++) @(negedge clk);
    if (jobs_done < target) begin
      check("job_timeout", jobs_done, target);
      finish_now();
    end
    repeat (5) @(negedge clk);
    toggle_empty = 0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mode_in = 1'b0;
    num_vec = '0;
    repeat (3) @(negedge clk);
    check("rst_l0_rd", l0_rd, 0);
    check("rst_inst_w", inst_w, INST_NOP);
    check("rst_mode", mode, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_phase", phase, ST_IDLE);
    reset = 1'b0;

    run_job(0, 4, 17, 0, 2);   // WS, never empty, stray start mid-job
    run_job(1, 3, -1, 0, 0);   // OS skips kernel phases
    run_job(0, 6, -1, 1, 0);   // WS with L0 toggling empty
    run_job(0, 0, -1, 0, 1);   // empty job, start held into DONE

    // Asynchronous reset during execute after two of five reads.
    push_job(0, 5, 17);
    @(negedge clk);
    start = 1'b1; mode_in = 1'b0; num_vec = 8'd5;
    @(negedge clk);
    start = 1'b0;
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(posedge clk);
        if (phase == ST_EXEC && exec_reads >= 2) break;
      end
      if (k == 200) begin
        check("rst_wait_timeout", k, 0);
        finish_now();
      end
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_l0_rd", l0_rd, 0);
    check("mid_rst_inst_w", inst_w, INST_NOP);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_phase", phase, ST_IDLE);
    job_q.delete();
    inst_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_job(0, 5, 17, 0, 0);   // fresh job after reset
    run_job(0, 255, 17, 0, 0); // full-range count, no wrap

    check("inst_q_drained", inst_q.size(), 0);
    check("job_q_drained", job_q.size(), 0);
    finish_now();
  end

endmodule
